id_decode_stage: RTL
====================

// Module: id_decode_stage
// PURPOSE
//  RV32I decode pipeline stage between instruction fetch and execute. Registers the
//  fetched instruction/PC with a valid/ready handshake and a one-entry skid buffer,
//  and decodes the fields, including the 3-bit imm_sel that drives the immediate
//  expander's opcode input. Registered outputs feed the immediate expander,
//  register file and ID/EX logic.
// PARAMETERS
//  XLEN      32   data/PC width; only 32 supported
//  RST_PC    0    value of id_pc after reset
// PORTS
//  clk        in   1     core clock, rising edge
//  rst_n      in   1     reset, asynchronous, active-low
//  flush      in   1     synchronous pipeline flush (branch/jump redirect)
//  if_valid   in   1     fetch offers if_inst/if_pc
//  if_ready   out  1     stage can accept; registered, = !skid_full
//  if_inst    in   32    fetched instruction
//  if_pc      in   32    PC of if_inst
//  id_valid   out  1     decoded instruction held on outputs
//  id_ready   in   1     execute consumes this cycle
//  id_inst    out  32    instruction (to immediate expander inst input)
//  id_pc      out  32    PC of id_inst
//  imm_sel    out  3     000 shamt,001 I,010 S,011 B,100 U,101 J,111 none
//  rs1/rs2/rd out  5 ea  inst[19:15]/[24:20]/[11:7]
//  funct3     out  3     inst[14:12]
//  funct7b5   out  1     inst[30]
//  reg_we     out  1     writes rd (forced 0 when rd==0)
//  illegal    out  1     unsupported opcode (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: id_valid=0, skid empty, if_ready=1, id_pc=RST_PC, id_inst=32'h00000013
//    (NOP), imm_sel=001, rs1/rs2/rd=0, funct3=0, funct7b5=0, reg_we=0, illegal=0.
//  - Transfer in when if_valid&if_ready; out when id_valid&id_ready.
//  - Latency: accepted instruction appears on id_* the next cycle if output reg is
//    empty or being consumed; else it goes to skid. Throughput 1/cycle.
//  - Skid: output busy & not consumed & input accepted -> store in skid, if_ready=0
//    next cycle. When output consumed and skid full -> skid moves to output, skid
//    clears, if_ready=1 next cycle. Order strictly preserved, no drops/duplicates.
//  - Output regs hold stable while id_valid&!id_ready.
//  - Decode on inst[6:0] (registered with the instruction, not combinational out):
//    0110011 OP      ->111 reg_we   | 0010011 OP-IMM ->funct3 001/101:000, else 001
//    0000011 LOAD    ->001 reg_we   | 1100111 JALR   ->001 reg_we
//    0100011 STORE   ->010          | 1100011 BRANCH ->011
//    0110111 LUI / 0010111 AUIPC ->100 reg_we | 1101111 JAL ->101 reg_we
//    1110011 SYSTEM  ->001, reg_we iff funct3!=0 | 0001111 FENCE ->111
//    any other       ->111, reg_we=0, illegal per CONFIGURATION
//  - OP-IMM shifts also set funct7b5=inst[30] (SRAI vs SRLI).
//  - flush: next cycle id_valid=0, skid empty, if_ready=1; a same-cycle input is
//    discarded. flush dominates id_ready and if_valid.
//  - Async reset mid-operation clears all state immediately; no partial outputs.
// CONFIGURATION
//  DECODE_ILLEGAL_CHK_EN defined: illegal=1 for unlisted opcodes and for
//   inst[1:0]!=2'b11; instruction still passes with reg_we=0, imm_sel=111.
//  Not defined: illegal tied to 0; unlisted opcodes decode as imm_sel=111, reg_we=0.
// TESTING
//  1 0x00500093 (addi x1,x0,5) -> next cycle id_valid=1,imm_sel=001,rd=1,rs1=0,reg_we=1
//  2 0x00409193 (slli x3,x1,4) -> imm_sel=000,funct3=001,rd=3; 0x0020A423 (sw) ->
//    imm_sel=010,reg_we=0; 0x00208463 (beq) -> 011; 0x123452B7 (lui x5) -> 100,rd=5
//  3 id_ready=0 3 cycles, 2 instrs offered back-to-back -> 2nd in skid, if_ready=0;
//    id_ready=1 -> both delivered in order, if_ready=1 after skid drains
//  4 flush with output+skid full and if_valid=1 -> next cycle id_valid=0,
//    if_ready=1; none of the three instructions ever appears on id_*
//  5 rst_n low mid-stream -> immediately id_valid=0,id_pc=RST_PC,id_inst=0x00000013
//  6 0x0000007F with DECODE_ILLEGAL_CHK_EN -> illegal=1,reg_we=0,imm_sel=111;
//    without macro -> illegal=0

Source files
------------

// File: rtl/id_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for id_decode_stage.
// The master side drives fetch/flush/consume; the slave side is the decode stage.
interface id_decode_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned ILEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 3;

   logic              flush;
   logic              if_valid;
   logic              if_ready;
   logic [ILEN-1:0]   if_inst;
   logic [XLEN-1:0]   if_pc;
   logic              id_valid;
   logic              id_ready;
   logic [ILEN-1:0]   id_inst;
   logic [XLEN-1:0]   id_pc;
   logic [SEL_W-1:0]  imm_sel;
   logic [REG_W-1:0]  rs1;
   logic [REG_W-1:0]  rs2;
   logic [REG_W-1:0]  rd;
   logic [2:0]        funct3;
   logic              funct7b5;
   logic              reg_we;
   logic              illegal;

   modport master (
      output flush, if_valid, if_inst, if_pc, id_ready,
      input  if_ready, id_valid, id_inst, id_pc, imm_sel, rs1, rs2, rd,
             funct3, funct7b5, reg_we, illegal
   );

   modport slave (
      input  flush, if_valid, if_inst, if_pc, id_ready,
      output if_ready, id_valid, id_inst, id_pc, imm_sel, rs1, rs2, rd,
             funct3, funct7b5, reg_we, illegal
   );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I decode stage: registered valid/ready stage with a one-entry skid buffer and
// field/immediate-select decode. Define DECODE_ILLEGAL_CHK_EN to flag unsupported opcodes.
module id_decode_stage #(
   parameter int unsigned     XLEN   = 32,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input  logic        clk,
   input  logic        rst_n,
   id_decode_if.slave  dec_if
);
   localparam int unsigned ILEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned OPC_W = 7;

   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   localparam logic [SEL_W-1:0] IMM_SHAMT = 3'b000;
   localparam logic [SEL_W-1:0] IMM_I     = 3'b001;
   localparam logic [SEL_W-1:0] IMM_S     = 3'b010;
   localparam logic [SEL_W-1:0] IMM_B     = 3'b011;
   localparam logic [SEL_W-1:0] IMM_U     = 3'b100;
   localparam logic [SEL_W-1:0] IMM_J     = 3'b101;
   localparam logic [SEL_W-1:0] IMM_NONE  = 3'b111;

   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

   typedef struct packed {
      logic [ILEN-1:0]  inst;
      logic [XLEN-1:0]  pc;
      logic [SEL_W-1:0] imm_sel;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [2:0]       funct3;
      logic             funct7b5;
      logic             reg_we;
      logic             illegal;
   } dec_t;

   localparam dec_t RST_DEC = '{
      inst:     NOP_INST,
      pc:       RST_PC,
      imm_sel:  IMM_I,
      rs1:      '0,
      rs2:      '0,
      rd:       '0,
      funct3:   '0,
      funct7b5: 1'b0,
      reg_we:   1'b0,
      illegal:  1'b0
   };

   // EMPTY: nothing held; BUSY: output reg full; FULL: output and skid full
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_BUSY  = 2'b01,
      S_FULL  = 2'b10
   } state_e;

   // Field and control decode; done before the register so outputs are flop-driven
   function automatic dec_t decode(input logic [ILEN-1:0] inst, input logic [XLEN-1:0] pc);
      dec_t d;
      d.inst     = inst;
      d.pc       = pc;
      d.rs1      = inst[19:15];
      d.rs2      = inst[24:20];
      d.rd       = inst[11:7];
      d.funct3   = inst[14:12];
      d.funct7b5 = inst[30];
      d.imm_sel  = IMM_NONE;
      d.reg_we   = 1'b0;
      d.illegal  = 1'b0;
      case (inst[6:0])
         OPC_OP: begin
            d.reg_we = 1'b1;
         end
         OPC_OP_IMM: begin
            d.imm_sel = (inst[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
            d.reg_we  = 1'b1;
         end
         OPC_LOAD, OPC_JALR: begin
            d.imm_sel = IMM_I;
            d.reg_we  = 1'b1;
         end
         OPC_STORE: begin
            d.imm_sel = IMM_S;
         end
         OPC_BRANCH: begin
            d.imm_sel = IMM_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            d.imm_sel = IMM_U;
            d.reg_we  = 1'b1;
         end
         OPC_JAL: begin
            d.imm_sel = IMM_J;
            d.reg_we  = 1'b1;
         end
         OPC_SYSTEM: begin
            d.imm_sel = IMM_I;
            d.reg_we  = (inst[14:12] != 3'b000);
         end
         OPC_FENCE: begin
            d.imm_sel = IMM_NONE;
         end
`ifdef DECODE_ILLEGAL_CHK_EN
         default: begin
            d.illegal = 1'b1;
         end
`else
         default: begin
            d.illegal = 1'b0;
         end
`endif
      endcase
`ifdef DECODE_ILLEGAL_CHK_EN
      if (inst[1:0] != 2'b11) begin
         d.illegal = 1'b1;
      end
`endif
      // x0 is never written
      d.reg_we = d.reg_we & (d.rd != '0);
      return d;
   endfunction

   state_e state_q, state_d;
   dec_t   out_q, out_d;
   dec_t   skid_q, skid_d;
   dec_t   in_dec_c;
   logic   id_valid_q, id_valid_d;
   logic   if_ready_q, if_ready_d;
   logic   accept_c;
   logic   fire_c;

   assign in_dec_c = decode(dec_if.if_inst, dec_if.if_pc);
   assign accept_c = dec_if.if_valid & if_ready_q & ~dec_if.flush;
   assign fire_c   = id_valid_q & dec_if.id_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: occupancy of output reg + skid
   always_comb begin
      state_d = state_q;
      if (dec_if.flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept_c) state_d = S_BUSY;
            end
            S_BUSY: begin
               if (fire_c && !accept_c)      state_d = S_EMPTY;
               else if (!fire_c && accept_c) state_d = S_FULL;
            end
            S_FULL: begin
               if (fire_c) state_d = S_BUSY;
            end
            default: begin
               state_d = S_EMPTY;
            end
         endcase
      end
   end

   // Output/datapath: steer incoming or skid entry into the output register
   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      id_valid_d = (state_d != S_EMPTY);
      if_ready_d = (state_d != S_FULL);
      if (!dec_if.flush) begin
         case (state_q)
            S_EMPTY: begin
               if (accept_c) out_d = in_dec_c;
            end
            S_BUSY: begin
               if (accept_c) begin
                  if (fire_c) out_d  = in_dec_c;
                  else        skid_d = in_dec_c;
               end
            end
            S_FULL: begin
               if (fire_c) out_d = skid_q;
            end
            default: begin
               out_d = out_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= RST_DEC;
         skid_q     <= RST_DEC;
         id_valid_q <= 1'b0;
         if_ready_q <= 1'b1;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         id_valid_q <= id_valid_d;
         if_ready_q <= if_ready_d;
      end
   end

   assign dec_if.if_ready = if_ready_q;
   assign dec_if.id_valid = id_valid_q;
   assign dec_if.id_inst  = out_q.inst;
   assign dec_if.id_pc    = out_q.pc;
   assign dec_if.imm_sel  = out_q.imm_sel;
   assign dec_if.rs1      = out_q.rs1;
   assign dec_if.rs2      = out_q.rs2;
   assign dec_if.rd       = out_q.rd;
   assign dec_if.funct3   = out_q.funct3;
   assign dec_if.funct7b5 = out_q.funct7b5;
   assign dec_if.reg_we   = out_q.reg_we;
   assign dec_if.illegal  = out_q.illegal;
endmodule
